// File: rtl/xor_reduce_pipe_if.sv
// Valid/ready bus of the pipelined XOR reducer: operand beat in, folded result out.
interface xor_reduce_pipe_if #(
  parameter int WIDTH      = 64,
  parameter int N_OPERANDS = 5,
  parameter int IN_DELAY   = 2
);
  localparam int LATENCY = IN_DELAY + $clog2(N_OPERANDS);
  localparam int CW      = $clog2(LATENCY + 1);

  logic                          in_valid;
  logic                          in_ready;
  logic [N_OPERANDS*WIDTH-1:0]   in_data;
  logic [N_OPERANDS-1:0]         in_mask;
  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0]              out_data;
  logic [CW-1:0]                 inflight;

  modport master (
    output in_valid, in_data, in_mask, out_ready,
    input  in_ready, out_valid, out_data, inflight
  );

  modport slave (
    input  in_valid, in_data, in_mask, out_ready,
    output in_ready, out_valid, out_data, inflight
  );
endinterface

// File: rtl/xor_reduce_pipe.sv
// N-operand XOR fold: IN_DELAY input registers, then a balanced binary tree with one
// register per level; the whole pipe advances together under a single stall signal.
module xor_reduce_pipe #(
  parameter int WIDTH      = 64,
  parameter int N_OPERANDS = 5,
  parameter int IN_DELAY   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  xor_reduce_pipe_if.slave bus
);
  localparam int LEVELS  = $clog2(N_OPERANDS);
  localparam int LATENCY = IN_DELAY + LEVELS;
  localparam int CW      = $clog2(LATENCY + 1);
  localparam int SLICE   = 48;
  localparam int SLICES  = (WIDTH + SLICE - 1) / SLICE;
  localparam int PW      = SLICES * SLICE;

  typedef logic [N_OPERANDS-1:0][PW-1:0] vec_t;

  logic                advance, accept, pop;
  logic [LATENCY-1:0]  vld_pipe;
  logic [CW-1:0]       inflight_q;
  vec_t                masked, lvl0;
  logic [LEVELS:1][N_OPERANDS-1:0][PW-1:0] tree_q;
  wire  [LEVELS:1][N_OPERANDS-1:0][PW-1:0] prev, nxt;

  assign advance       = !vld_pipe[LATENCY-1] || bus.out_ready;
  assign accept        = bus.in_valid && advance;
  assign pop           = vld_pipe[LATENCY-1] && bus.out_ready;
  assign bus.in_ready  = !rst_n || advance;
  assign bus.out_valid = vld_pipe[LATENCY-1];
  assign bus.out_data  = tree_q[LEVELS][0][WIDTH-1:0];
  assign bus.inflight  = inflight_q;

  // Operands are widened to whole 48-bit slices; pad bits stay zero through the tree.
  always_comb begin
    masked = '0;
    for (int k = 0; k < N_OPERANDS; k++)
      if (bus.in_mask[k]) masked[k][WIDTH-1:0] = bus.in_data[k*WIDTH +: WIDTH];
  end

  if (IN_DELAY == 0) begin : g_nodly
    assign lvl0 = masked;
  end else begin : g_dly
    logic [IN_DELAY-1:0][N_OPERANDS-1:0][PW-1:0] dly_q;
    always_ff @(posedge clk) begin
      if (!rst_n) dly_q <= '0;
      else if (advance) begin
        dly_q[0] <= masked;
        for (int i = 1; i < IN_DELAY; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign lvl0 = dly_q[IN_DELAY-1];
  end

  // Node i of level j folds nodes 2i and 2i+1 of the level below; odd tail passes through.
  for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
    if (j == 1) begin : g_src0
      assign prev[j] = lvl0;
    end else begin : g_srcn
      assign prev[j] = tree_q[j-1];
    end
    for (genvar i = 0; i < N_OPERANDS; i++) begin : g_node
      for (genvar s = 0; s < SLICES; s++) begin : g_slice
        if (2*i+1 < N_OPERANDS) begin : g_xor
          assign nxt[j][i][s*SLICE +: SLICE] =
            prev[j][2*i][s*SLICE +: SLICE] ^ prev[j][2*i+1][s*SLICE +: SLICE];
        end else if (2*i < N_OPERANDS) begin : g_pass
          assign nxt[j][i][s*SLICE +: SLICE] = prev[j][2*i][s*SLICE +: SLICE];
        end else begin : g_zero
          assign nxt[j][i][s*SLICE +: SLICE] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tree_q <= '0;
    else if (advance) tree_q <= nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe <= '0;
    else if (advance) begin
      vld_pipe[0] <= accept;
      for (int k = 1; k < LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) inflight_q <= '0;
    else if (accept && !pop) inflight_q <= inflight_q + CW'(1);
    else if (!accept && pop) inflight_q <= inflight_q - CW'(1);
  end

  // Only node 0 of the top level, low WIDTH bits, leaves the block.
  logic unused_tail;
  assign unused_tail = ^tree_q[LEVELS];
endmodule

// File: tb/tb_xor_reduce_pipe.sv
// Scoreboard bench for two configurations: 64b x 5 with 2 input delays, and 100b x 2 with none.
module tb_xor_reduce_pipe;
  localparam int AW = 64, AN = 5, AD = 2, ALAT = 5;
  localparam int BW = 100, BN = 2, BD = 0, BLAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xor_reduce_pipe_if #(.WIDTH(AW), .N_OPERANDS(AN), .IN_DELAY(AD)) ba();
  xor_reduce_pipe_if #(.WIDTH(BW), .N_OPERANDS(BN), .IN_DELAY(BD)) bb();

  xor_reduce_pipe #(.WIDTH(AW), .N_OPERANDS(AN), .IN_DELAY(AD)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  xor_reduce_pipe #(.WIDTH(BW), .N_OPERANDS(BN), .IN_DELAY(BD)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

  int vecs = 0, errs = 0;
  int mdl_a = 0, mdl_b = 0, max_a = 0;
  logic [AW-1:0] qa[$];
  logic [BW-1:0] qb[$];
  bit rnd_on = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [AN*AW-1:0] pk_a(input logic [AW-1:0] o0, o1, o2, o3, o4);
    return {o4, o3, o2, o1, o0};
  endfunction

  // Monitors: pop expected results on each output handshake; track inflight against beat counts.
  initial forever begin
    @(negedge clk);
    if (!rst_n) mdl_a = 0;
    else begin
      chk("a_inflight", 128'(ba.inflight), 128'(mdl_a));
      if (int'(ba.inflight) > max_a) max_a = int'(ba.inflight);
      if (ba.out_valid && ba.out_ready) begin
        if (qa.size() == 0) begin
          errs++; $display("FAIL a_unexpected got %h want none", ba.out_data);
        end else chk("a_data", 128'(ba.out_data), 128'(qa.pop_front()));
      end
      mdl_a = mdl_a + int'(ba.in_valid && ba.in_ready) - int'(ba.out_valid && ba.out_ready);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) mdl_b = 0;
    else begin
      chk("b_inflight", 128'(bb.inflight), 128'(mdl_b));
      if (bb.out_valid && bb.out_ready) begin
        if (qb.size() == 0) begin
          errs++; $display("FAIL b_unexpected got %h want none", bb.out_data);
        end else chk("b_data", 128'(bb.out_data), 128'(qb.pop_front()));
      end
      mdl_b = mdl_b + int'(bb.in_valid && bb.in_ready) - int'(bb.out_valid && bb.out_ready);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_a(input logic [AN*AW-1:0] d, input logic [AN-1:0] m, input logic [AW-1:0] want);
    bit acc = 0;
    int n = 0;
    ba.in_valid = 1'b1; ba.in_data = d; ba.in_mask = m;
    while (!acc && n < 200) begin
      @(negedge clk); acc = ba.in_ready;
      @(posedge clk); #1; n++;
    end
    ba.in_valid = 1'b0;
    if (acc) begin qa.push_back(want); vecs++; end
    else begin errs++; $display("FAIL a_accept_timeout got %0d cycles want accept", n); end
  endtask

  task automatic send_b(input logic [BN*BW-1:0] d, input logic [BN-1:0] m, input logic [BW-1:0] want);
    bit acc = 0;
    int n = 0;
    bb.in_valid = 1'b1; bb.in_data = d; bb.in_mask = m;
    while (!acc && n < 200) begin
      @(negedge clk); acc = bb.in_ready;
      @(posedge clk); #1; n++;
    end
    bb.in_valid = 1'b0;
    if (acc) begin qb.push_back(want); vecs++; end
    else begin errs++; $display("FAIL b_accept_timeout got %0d cycles want accept", n); end
  endtask

  task automatic drain(input bit is_b, output int n);
    n = 0;
    while ((is_b ? qb.size() : qa.size()) != 0 && n < 400) begin @(posedge clk); #1; n++; end
    if ((is_b ? qb.size() : qa.size()) != 0) begin
      errs++; $display("FAIL drain_timeout got %0d left want 0", is_b ? qb.size() : qa.size());
    end
  endtask

  // Cycles from the accept cycle (counted as 1) to the first out_valid cycle.
  task automatic latency(input bit is_b, output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if ((is_b ? bb.out_valid : ba.out_valid) || lat > 50) break;
      lat++;
      @(posedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n, lat;
    logic [AW-1:0] hold;
    logic [BW-1:0] ra, rb;
    logic [BN-1:0] rm;
    ba.in_valid = 0; ba.in_data = '0; ba.in_mask = '0; ba.out_ready = 1'b0;
    bb.in_valid = 0; bb.in_data = '0; bb.in_mask = '0; bb.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_rst_valid",   128'(ba.out_valid), 128'(0));
    chk("a_rst_data",    128'(ba.out_data),  128'(0));
    chk("a_rst_inflight",128'(ba.inflight),  128'(0));
    chk("a_rst_ready",   128'(ba.in_ready),  128'(1));
    chk("b_rst_valid",   128'(bb.out_valid), 128'(0));
    chk("b_rst_data",    128'(bb.out_data),  128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; ba.out_ready = 1'b1; bb.out_ready = 1'b1;

    // Single-hot operands, various masks; latency from accept to out_valid.
    send_a(pk_a(64'h1, 64'h2, 64'h4, 64'h8, 64'h10), 5'h1F, 64'h1F);
    latency(0, lat);
    chk("a_latency", 128'(lat), 128'(ALAT));
    drain(0, n);
    send_a(pk_a(64'h1, 64'h2, 64'h4, 64'h8, 64'h10), 5'b00101, 64'h05);
    send_a(pk_a(64'h1, 64'h2, 64'h4, 64'h8, 64'h10), 5'b00000, 64'h00);
    send_a(pk_a(64'h1, 64'h2, 64'h4, 64'h8, 64'h10), 5'b11010, 64'h1A);
    send_a(pk_a(64'hFFFF0000FFFF0000, 64'h00FF00FF00FF00FF, 64'h0, 64'h0, 64'h8000000000000001),
           5'h1F, 64'h7F0000FFFF0000FE);
    drain(0, n);

    // Back-to-back stream at full throughput.
    repeat (3) @(posedge clk); #1;
    max_a = 0;
    for (int i = 0; i < 8; i++) send_a(pk_a(64'(i), 64'h0, 64'h0, 64'h0, 64'h0), 5'h1F, 64'(i));
    drain(0, n);
    chk("a_b2b_drain", 128'(n), 128'(5));
    chk("a_inflight_max", 128'(max_a), 128'(ALAT));

    // Fill pipe with out_ready low, hold for 10 cycles, then release.
    ba.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_a(pk_a(64'h10 + 64'(i), 64'h0, 64'h0, 64'h0, 64'h0), 5'h01, 64'h10 + 64'(i));
    hold = qa[0];
    repeat (10) begin
      @(negedge clk);
      chk("a_stall_ready", 128'(ba.in_ready),  128'(0));
      chk("a_stall_valid", 128'(ba.out_valid), 128'(1));
      chk("a_stall_data",  128'(ba.out_data),  128'(hold));
      chk("a_stall_infl",  128'(ba.inflight),  128'(5));
      @(posedge clk); #1;
    end
    ba.out_ready = 1'b1;
    drain(0, n);

    // Reset with three beats in flight: they must vanish.
    for (int i = 0; i < 3; i++) send_a(pk_a(64'hDEAD0 + 64'(i), 64'h0, 64'h0, 64'h0, 64'h0), 5'h1F, 64'hDEAD0 + 64'(i));
    rst_n = 1'b0;
    @(negedge clk);
    chk("a_rst_in_ready", 128'(ba.in_ready), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    qa.delete();
    @(negedge clk);
    chk("a_post_rst_valid",    128'(ba.out_valid), 128'(0));
    chk("a_post_rst_inflight", 128'(ba.inflight),  128'(0));
    repeat (10) @(posedge clk);
    #1;

    // 100-bit, two operands, no input delay.
    send_b({100'hA5, {BW{1'b1}}}, 2'b11, 100'hFFFFFFFFFFFFFFFFFFFFFFF5A);
    latency(1, lat);
    chk("b_latency", 128'(lat), 128'(BLAT));
    send_b({100'hA5, {BW{1'b1}}}, 2'b01, {BW{1'b1}});
    send_b({100'hA5, {BW{1'b1}}}, 2'b10, 100'hA5);
    send_b({100'hA5, {BW{1'b1}}}, 2'b00, 100'h0);
    drain(1, n);

    // Random beats against a reference fold, with random backpressure.
    rnd_on = 1;
    fork
      while (rnd_on) begin @(posedge clk); #1; bb.out_ready = ($urandom_range(0, 9) < 7); end
    join_none
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rm = BN'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send_b({rb, ra}, rm, (rm[0] ? ra : '0) ^ (rm[1] ? rb : '0));
    end
    rnd_on = 0;
    @(posedge clk); #2;
    bb.out_ready = 1'b1;
    drain(1, n);
    drain(0, n);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
